// File: rtl/trig_route_gen.sv
// Trigger router/conditioner: selects one source, detects level/edge events, emits a delayed,
// width-programmable pulse with arm/one-shot control, a saturating fire count and a heartbeat.
module trig_route_gen #(
  parameter int unsigned pNUM_SRC     = 4,
  parameter int unsigned pDELAY_WIDTH = 16,
  parameter int unsigned pPW_WIDTH    = 16,
  parameter int unsigned pCNT_WIDTH   = 16,
  parameter int unsigned pHB_WIDTH    = 23
) (
  input  logic                        ext_clock,
  input  logic                        resetn,
  input  logic [pNUM_SRC-1:0]         I_src,
  input  logic [$clog2(pNUM_SRC)-1:0] I_sel,
  input  logic                        I_edge_mode,
  input  logic [pDELAY_WIDTH-1:0]     I_delay,
  input  logic [pPW_WIDTH-1:0]        I_pulse_width,
  input  logic                        I_oneshot,
  input  logic                        I_arm,
  input  logic                        I_disarm,
  input  logic                        I_cnt_clr,
  output logic                        O_trig,
  output logic                        O_armed,
  output logic                        O_busy,
  output logic [pCNT_WIDTH-1:0]       O_trig_count,
  output logic                        O_heartbeat
);

  localparam int unsigned SelW = $clog2(pNUM_SRC);
  localparam int unsigned ExtW = 1 << SelW;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StArmed = 2'd1;
  localparam logic [1:0] StDelay = 2'd2;
  localparam logic [1:0] StPulse = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [pNUM_SRC-1:0]     src_q;
  logic [SelW-1:0]         sel_q;
  logic                    edge_q;
  logic [pDELAY_WIDTH-1:0] delay_q;
  logic [pPW_WIDTH-1:0]    pw_q;
  logic                    oneshot_q;
  logic [pDELAY_WIDTH-1:0] dcnt_q, dcnt_d;
  logic [pPW_WIDTH-1:0]    pcnt_q, pcnt_d;
  logic                    trig_q, trig_d;
  logic [pCNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [pHB_WIDTH-1:0]    hb_q;
  logic                    cfg_load;
  logic                    pulse_entry;
  logic                    evt;

  // Zero-extend so unused select codes read as a source that never goes high.
  logic [ExtW-1:0] src_ext, srcq_ext;
  assign src_ext  = ExtW'(I_src);
  assign srcq_ext = ExtW'(src_q);
  assign evt      = src_ext[sel_q] & (~edge_q | ~srcq_ext[sel_q]);

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    pcnt_d      = pcnt_q;
    trig_d      = trig_q;
    cfg_load    = 1'b0;
    pulse_entry = 1'b0;
    if (I_disarm) begin
      state_d = StIdle;
      trig_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (I_arm) begin
            state_d  = StArmed;
            cfg_load = 1'b1;
          end
        end
        StArmed: begin
          if (evt) begin
            if (delay_q == '0) begin
              pulse_entry = 1'b1;
            end else begin
              state_d = StDelay;
              dcnt_d  = delay_q - pDELAY_WIDTH'(1);
            end
          end
        end
        StDelay: begin
          if (dcnt_q == '0) pulse_entry = 1'b1;
          else              dcnt_d      = dcnt_q - pDELAY_WIDTH'(1);
        end
        StPulse: begin
          if (pcnt_q == '0) begin
            trig_d  = 1'b0;
            state_d = oneshot_q ? StIdle : StArmed;
          end else begin
            pcnt_d = pcnt_q - pPW_WIDTH'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
    // A zero width still yields a single-cycle pulse.
    if (pulse_entry) begin
      state_d = StPulse;
      trig_d  = 1'b1;
      pcnt_d  = (pw_q == '0) ? '0 : pw_q - pPW_WIDTH'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (I_cnt_clr)                   cnt_d = '0;
    else if (pulse_entry && !(&cnt_q)) cnt_d = cnt_q + pCNT_WIDTH'(1);
  end

  always_ff @(posedge ext_clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      src_q     <= '0;
      sel_q     <= '0;
      edge_q    <= 1'b0;
      delay_q   <= '0;
      pw_q      <= '0;
      oneshot_q <= 1'b0;
      dcnt_q    <= '0;
      pcnt_q    <= '0;
      trig_q    <= 1'b0;
      cnt_q     <= '0;
      hb_q      <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= I_src;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
      trig_q  <= trig_d;
      cnt_q   <= cnt_d;
      if (!trig_q) hb_q <= hb_q + pHB_WIDTH'(1);
      if (cfg_load) begin
        sel_q     <= I_sel;
        edge_q    <= I_edge_mode;
        delay_q   <= I_delay;
        pw_q      <= I_pulse_width;
        oneshot_q <= I_oneshot;
      end
    end
  end

  assign O_trig       = trig_q;
  assign O_armed      = (state_q == StArmed);
  assign O_busy       = (state_q == StDelay) || (state_q == StPulse);
  assign O_trig_count = cnt_q;
  assign O_heartbeat  = hb_q[pHB_WIDTH-1];

endmodule

// File: tb/tb_trig_route_gen.sv
// Bench for trig_route_gen: directed scenarios plus randomized traffic against a
// time-window reference model (pulse = [event+delay, event+delay+width)).
module tb_trig_route_gen;
  localparam int NS = 3;
  localparam int DW = 8;
  localparam int PWW = 8;
  localparam int CW = 4;
  localparam int HW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          ext_clock = 1'b0;
  logic          resetn = 1'b0;
  logic [NS-1:0] I_src = '0;
  logic [1:0]    I_sel = '0;
  logic          I_edge_mode = 1'b0;
  logic [DW-1:0] I_delay = '0;
  logic [PWW-1:0] I_pulse_width = '0;
  logic          I_oneshot = 1'b0;
  logic          I_arm = 1'b0;
  logic          I_disarm = 1'b0;
  logic          I_cnt_clr = 1'b0;
  logic          O_trig, O_armed, O_busy, O_heartbeat;
  logic [CW-1:0] O_trig_count;

  int checks = 0;
  int errors = 0;

  trig_route_gen #(
    .pNUM_SRC(NS), .pDELAY_WIDTH(DW), .pPW_WIDTH(PWW), .pCNT_WIDTH(CW), .pHB_WIDTH(HW)
  ) dut (
    .ext_clock(ext_clock), .resetn(resetn), .I_src(I_src), .I_sel(I_sel),
    .I_edge_mode(I_edge_mode), .I_delay(I_delay), .I_pulse_width(I_pulse_width),
    .I_oneshot(I_oneshot), .I_arm(I_arm), .I_disarm(I_disarm), .I_cnt_clr(I_cnt_clr),
    .O_trig(O_trig), .O_armed(O_armed), .O_busy(O_busy), .O_trig_count(O_trig_count),
    .O_heartbeat(O_heartbeat)
  );

  always #5 ext_clock = ~ext_clock;

  // Reference model: time-based, pulse described by its start/end cycle.
  int t = 0;
  int m_sel, m_delay, m_pw, m_start, m_end, m_cnt, m_hb;
  logic m_edge, m_oneshot, m_armed, m_win, m_trig;
  logic [NS-1:0] m_prev;

  task automatic model_reset();
    m_sel = 0; m_delay = 0; m_pw = 0; m_start = 0; m_end = 0; m_cnt = 0; m_hb = 0;
    m_edge = 0; m_oneshot = 0; m_armed = 0; m_win = 0; m_trig = 0; m_prev = '0;
  endtask

  task automatic model_step();
    logic ev;
    ev = 1'b0;
    if (m_sel < NS) ev = I_src[m_sel] && (!m_edge || !m_prev[m_sel]);
    if (!m_trig) m_hb = (m_hb + 1) % (1 << HW);
    if (I_disarm) begin
      m_armed = 0; m_win = 0;
    end else if (m_win) begin
      if (t == m_end) begin m_win = 0; m_armed = !m_oneshot; end
    end else if (m_armed) begin
      if (ev) begin
        m_win = 1; m_armed = 0;
        m_start = t + m_delay;
        m_end = m_start + ((m_pw == 0) ? 1 : m_pw);
      end
    end else if (I_arm) begin
      m_sel = int'(I_sel); m_edge = I_edge_mode; m_delay = int'(I_delay);
      m_pw = int'(I_pulse_width); m_oneshot = I_oneshot; m_armed = 1;
    end
    if (I_cnt_clr) m_cnt = 0;
    else if (m_win && t == m_start && m_cnt < CMAX) m_cnt++;
    m_trig = m_win && t >= m_start && t < m_end;
    m_prev = I_src;
    t++;
  endtask

  task automatic tick();
    @(posedge ext_clock);
    if (!resetn) model_reset();
    else model_step();
    #1;
  endtask

  task automatic set_cfg(input int sel, input int edm, input int dly, input int pw, input int os);
    I_sel = 2'(sel); I_edge_mode = 1'(edm); I_delay = DW'(dly);
    I_pulse_width = PWW'(pw); I_oneshot = 1'(os);
  endtask

  task automatic do_arm();    I_arm = 1; tick(); I_arm = 0;       endtask
  task automatic do_disarm(); I_disarm = 1; tick(); I_disarm = 0; endtask
  task automatic do_clr();    I_cnt_clr = 1; tick(); I_cnt_clr = 0; endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({O_trig, O_armed, O_busy, O_heartbeat, O_trig_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0", {O_trig, O_armed, O_busy, O_heartbeat, O_trig_count});
    end
    tick(); tick();
    resetn = 1;
    repeat (20) begin
      tick();
      checks++;
      if (O_heartbeat !== m_hb[HW-1] || O_armed !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle hb %b armed %b exp hb %b armed 0", O_heartbeat, O_armed, m_hb[HW-1]);
      end
    end
  endtask

  task automatic test_level_oneshot();
    do_clr();
    set_cfg(1, 0, 0, 1, 1);
    do_arm();
    checks++;
    if (O_armed !== 1'b1) begin errors++; $display("FAIL lvl_armed got %b exp 1", O_armed); end
    repeat (3) tick();
    I_src = 3'b010; tick();
    checks++;
    if (O_trig !== 1'b1 || O_trig_count !== 4'd1) begin
      errors++; $display("FAIL lvl_fire trig %b cnt %0d exp 1 1", O_trig, O_trig_count);
    end
    I_src = '0; tick();
    checks++;
    if (O_trig !== 1'b0 || O_armed !== 1'b0 || O_busy !== 1'b0 || O_trig_count !== 4'd1) begin
      errors++;
      $display("FAIL lvl_after trig %b armed %b busy %b cnt %0d exp 0 0 0 1",
               O_trig, O_armed, O_busy, O_trig_count);
    end
  endtask

  task automatic test_edge_delay();
    do_clr();
    set_cfg(2, 1, 5, 3, 0);
    do_arm();
    I_src = 3'b100;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (O_trig !== 1'((k >= 6) && (k <= 8))) begin
        errors++; $display("FAIL edge_trig k %0d got %b exp %b", k, O_trig, (k >= 6) && (k <= 8));
      end
    end
    checks++;
    if (O_trig_count !== 4'd1 || O_armed !== 1'b1) begin
      errors++; $display("FAIL edge_hold cnt %0d armed %b exp 1 1", O_trig_count, O_armed);
    end
    do_disarm();
    I_src = '0;
  endtask

  task automatic test_autorearm_level();
    do_clr();
    set_cfg(0, 0, 0, 2, 0);
    do_arm();
    I_src = 3'b001;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (O_trig !== 1'(((k - 1) % 3) != 2)) begin
        errors++; $display("FAIL rearm_trig k %0d got %b exp %b", k, O_trig, ((k - 1) % 3) != 2);
      end
    end
    checks++;
    if (O_trig_count !== 4'd4) begin
      errors++; $display("FAIL rearm_cnt got %0d exp 4", O_trig_count);
    end
    do_disarm();
    I_src = '0;
  endtask

  task automatic test_disarm();
    set_cfg(1, 0, 100, 4, 1);
    do_arm();
    I_src = 3'b010; tick(); I_src = '0;
    for (int k = 0; k < 39; k++) begin
      tick();
      checks++;
      if (O_trig !== 1'b0 || O_busy !== 1'b1) begin
        errors++; $display("FAIL dis_delay k %0d trig %b busy %b exp 0 1", k, O_trig, O_busy);
      end
    end
    do_disarm();
    checks++;
    if (O_busy !== 1'b0 || O_armed !== 1'b0) begin
      errors++; $display("FAIL dis_idle busy %b armed %b exp 0 0", O_busy, O_armed);
    end
    for (int k = 0; k < 80; k++) begin
      tick();
      checks++;
      if (O_trig !== 1'b0) begin errors++; $display("FAIL dis_quiet k %0d got %b exp 0", k, O_trig); end
    end
    do_clr();
    set_cfg(1, 0, 0, 10, 1);
    do_arm();
    I_src = 3'b010; tick(); I_src = '0;
    repeat (3) tick();
    checks++;
    if (O_trig !== 1'b1) begin errors++; $display("FAIL dis_pulse got %b exp 1", O_trig); end
    do_disarm();
    checks++;
    if (O_trig !== 1'b0 || O_busy !== 1'b0 || O_trig_count !== 4'd1) begin
      errors++; $display("FAIL dis_abort trig %b busy %b cnt %0d exp 0 0 1", O_trig, O_busy, O_trig_count);
    end
    I_arm = 1; I_disarm = 1; tick(); I_arm = 0; I_disarm = 0;
    checks++;
    if (O_armed !== 1'b0) begin errors++; $display("FAIL arm_vs_disarm got %b exp 0", O_armed); end
  endtask

  task automatic test_saturate();
    do_clr();
    set_cfg(0, 0, 0, 1, 0);
    do_arm();
    I_src = 3'b001;
    for (int k = 0; k < 45; k++) begin
      tick();
      checks++;
      if (O_trig_count !== CW'(m_cnt) || O_trig !== m_trig) begin
        errors++;
        $display("FAIL sat_run k %0d cnt %0d trig %b exp %0d %b", k, O_trig_count, O_trig, m_cnt, m_trig);
      end
    end
    checks++;
    if (O_trig_count !== 4'd15) begin errors++; $display("FAIL sat_max got %0d exp 15", O_trig_count); end
    for (int k = 0; k < 4 && !m_armed; k++) tick();
    I_cnt_clr = 1; tick(); I_cnt_clr = 0;
    checks++;
    if (O_trig_count !== 4'd0 || O_trig !== 1'b1) begin
      errors++; $display("FAIL clr_wins cnt %0d trig %b exp 0 1", O_trig_count, O_trig);
    end
    tick(); tick();
    checks++;
    if (O_trig_count !== 4'd1) begin errors++; $display("FAIL clr_next got %0d exp 1", O_trig_count); end
    do_disarm();
    I_src = '0;
  endtask

  task automatic test_misc();
    set_cfg(0, 0, 0, 0, 1);
    do_arm();
    I_src = 3'b001; tick(); I_src = '0;
    checks++;
    if (O_trig !== 1'b1) begin errors++; $display("FAIL pw0_high got %b exp 1", O_trig); end
    tick();
    checks++;
    if (O_trig !== 1'b0 || O_armed !== 1'b0) begin
      errors++; $display("FAIL pw0_low trig %b armed %b exp 0 0", O_trig, O_armed);
    end
    set_cfg(NS, 0, 0, 1, 0);
    do_arm();
    I_src = 3'b111;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (O_trig !== 1'b0 || O_armed !== 1'b1) begin
        errors++; $display("FAIL badsel k %0d trig %b armed %b exp 0 1", k, O_trig, O_armed);
      end
    end
    do_disarm();
    I_src = '0;
    set_cfg(0, 0, 2, 20, 1);
    do_arm();
    I_src = 3'b001; tick(); I_src = '0;
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++;
      if (O_heartbeat !== m_hb[HW-1] || O_trig !== m_trig) begin
        errors++;
        $display("FAIL hb_freeze k %0d hb %b trig %b exp %b %b", k, O_heartbeat, O_trig, m_hb[HW-1], m_trig);
      end
    end
    set_cfg(0, 0, 0, 10, 1);
    do_arm();
    I_src = 3'b001; tick(); I_src = '0; tick();
    checks++;
    if (O_trig !== 1'b1) begin errors++; $display("FAIL rst_pre got %b exp 1", O_trig); end
    #2 resetn = 0;
    #1;
    checks++;
    if ({O_trig, O_armed, O_busy, O_heartbeat, O_trig_count} !== '0) begin
      errors++;
      $display("FAIL rst_async got %b exp 0", {O_trig, O_armed, O_busy, O_heartbeat, O_trig_count});
    end
    tick(); tick();
    resetn = 1;
    tick();
    checks++;
    if (O_trig !== 1'b0 || O_busy !== 1'b0 || O_trig_count !== 4'd0) begin
      errors++; $display("FAIL rst_after trig %b busy %b cnt %0d exp 0 0 0", O_trig, O_busy, O_trig_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      I_src = 3'($urandom);
      I_sel = 2'($urandom_range(0, 3));
      I_edge_mode = 1'($urandom);
      I_delay = DW'($urandom_range(0, 6));
      I_pulse_width = PWW'($urandom_range(0, 4));
      I_oneshot = 1'($urandom);
      I_arm = ($urandom_range(0, 7) == 0);
      I_disarm = ($urandom_range(0, 39) == 0);
      I_cnt_clr = ($urandom_range(0, 63) == 0);
      tick();
      checks++;
      if (O_trig !== m_trig || O_armed !== m_armed || O_busy !== m_win ||
          O_trig_count !== CW'(m_cnt) || O_heartbeat !== m_hb[HW-1]) begin
        errors++;
        $display("FAIL rand cyc %0d got t%b a%b b%b c%0d h%b exp t%b a%b b%b c%0d h%b", i,
                 O_trig, O_armed, O_busy, O_trig_count, O_heartbeat,
                 m_trig, m_armed, m_win, m_cnt, m_hb[HW-1]);
      end
    end
    I_arm = 0; I_disarm = 0; I_cnt_clr = 0; I_src = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_level_oneshot();
    test_edge_delay();
    test_autorearm_level();
    test_disarm();
    test_saturate();
    test_misc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
